// File: rtl/ecsu_pkg.sv
// ecsu_pkg: shared definitions for the environmental condition safety unit.
//   - ecsu_state_e : 2-bit alert level encoding (ALL_CLEAR .. EMERGENCY)
//   - VIS_*        : visibility input codes
//   - cnt_w()      : width needed for a counter that must hold values 0..n
package ecsu_pkg;

  typedef enum logic [1:0] {
    ALL_CLEAR  = 2'b00,
    CAUTION    = 2'b01,
    HIGH_ALERT = 2'b10,
    EMERGENCY  = 2'b11
  } ecsu_state_e;

  localparam logic [1:0] VIS_CLEAR   = 2'b00;
  localparam logic [1:0] VIS_REDUCED = 2'b01;
  localparam logic [1:0] VIS_POOR    = 2'b10;
  localparam logic [1:0] VIS_ZERO    = 2'b11;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ecsu_classify.sv
// ecsu_classify: combinational sensor classifier. Maps one sensor sample to
// the target alert level; the highest matching rule wins.
// Ports:
//   thunderstorm  in  thunderstorm detected
//   wind          in  unsigned wind speed, WIND_W bits
//   visibility    in  visibility code (see ecsu_pkg VIS_*)
//   temperature   in  signed temperature, TEMP_W bits
//   target        out target alert level
module ecsu_classify
  import ecsu_pkg::*;
#(
  parameter int WIND_W       = 6,
  parameter int TEMP_W       = 8,
  parameter int CAUTION_WIND = 10,
  parameter int HIGH_WIND    = 15,
  parameter int EMERG_WIND   = 20,
  parameter int HIGH_TEMP    = 35,
  parameter int EMERG_TEMP   = 40
) (
  input  logic                     thunderstorm,
  input  logic        [WIND_W-1:0] wind,
  input  logic        [1:0]        visibility,
  input  logic signed [TEMP_W-1:0] temperature,
  output ecsu_state_e              target
);

  localparam logic [WIND_W-1:0] CAUTION_W = WIND_W'(CAUTION_WIND);
  localparam logic [WIND_W-1:0] HIGH_W    = WIND_W'(HIGH_WIND);
  localparam logic [WIND_W-1:0] EMERG_W   = WIND_W'(EMERG_WIND);

  // Temperature limits held as signed TEMP_W values so both bounds compare
  // as two's complement against the sample.
  localparam logic signed [TEMP_W-1:0] HIGH_T_POS  = TEMP_W'(HIGH_TEMP);
  localparam logic signed [TEMP_W-1:0] HIGH_T_NEG  = TEMP_W'(-HIGH_TEMP);
  localparam logic signed [TEMP_W-1:0] EMERG_T_POS = TEMP_W'(EMERG_TEMP);
  localparam logic signed [TEMP_W-1:0] EMERG_T_NEG = TEMP_W'(-EMERG_TEMP);

  logic emerg_hit;
  logic high_hit;
  logic caution_hit;

  always_comb begin
    emerg_hit   = (wind > EMERG_W) ||
                  (temperature > EMERG_T_POS) || (temperature < EMERG_T_NEG);
    high_hit    = (wind > HIGH_W) || (visibility == VIS_ZERO) ||
                  (temperature > HIGH_T_POS) || (temperature < HIGH_T_NEG) ||
                  thunderstorm;
    caution_hit = (wind > CAUTION_W) ||
                  (visibility == VIS_REDUCED) || (visibility == VIS_POOR);

    if (emerg_hit)        target = EMERGENCY;
    else if (high_hit)    target = HIGH_ALERT;
    else if (caution_hit) target = CAUTION;
    else                  target = ALL_CLEAR;
  end

endmodule

// File: rtl/ecsu_persist.sv
// ecsu_persist: alert-level state machine with persistence filtering.
// Escalates after ESC_CYCLES consecutive higher-target samples, drops one
// level after CLR_CYCLES consecutive lower-target samples, and leaves
// EMERGENCY only on an acknowledged calmer sample.
// Ports:
//   CLK, RST                 clock (rising edge), async active-high reset
//   sample_valid             sensor inputs valid this cycle
//   thunderstorm, wind,
//   visibility, temperature  sensor sample
//   ack                      operator acknowledge (EMERGENCY only)
//   severe_weather           state is HIGH_ALERT or EMERGENCY
//   emergency_landing_alert  state is EMERGENCY
//   ECSU_state               current alert level
//   state_changed            one-cycle pulse after any transition
module ecsu_persist
  import ecsu_pkg::*;
#(
  parameter int WIND_W       = 6,
  parameter int TEMP_W       = 8,
  parameter int CAUTION_WIND = 10,
  parameter int HIGH_WIND    = 15,
  parameter int EMERG_WIND   = 20,
  parameter int HIGH_TEMP    = 35,
  parameter int EMERG_TEMP   = 40,
  parameter int ESC_CYCLES   = 2,
  parameter int CLR_CYCLES   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     sample_valid,
  input  logic                     thunderstorm,
  input  logic        [WIND_W-1:0] wind,
  input  logic        [1:0]        visibility,
  input  logic signed [TEMP_W-1:0] temperature,
  input  logic                     ack,
  output logic                     severe_weather,
  output logic                     emergency_landing_alert,
  output logic        [1:0]        ECSU_state,
  output logic                     state_changed
);

  if (!(CAUTION_WIND < HIGH_WIND && HIGH_WIND < EMERG_WIND)) begin : g_bad_wind
    $error("ecsu_persist: wind thresholds must be strictly increasing");
  end
  if (!(HIGH_TEMP < EMERG_TEMP)) begin : g_bad_temp
    $error("ecsu_persist: HIGH_TEMP must be below EMERG_TEMP");
  end
  if (ESC_CYCLES < 1 || CLR_CYCLES < 1) begin : g_bad_cycles
    $error("ecsu_persist: ESC_CYCLES and CLR_CYCLES must be at least 1");
  end

  localparam int CNT_W = cnt_w((ESC_CYCLES > CLR_CYCLES) ? ESC_CYCLES : CLR_CYCLES);
  localparam logic [CNT_W-1:0] ESC_LIM = CNT_W'(ESC_CYCLES);
  localparam logic [CNT_W-1:0] CLR_LIM = CNT_W'(CLR_CYCLES);

  // Stage p0: combinational classification of the incoming sample
  ecsu_state_e target_p0;

  ecsu_classify #(
    .WIND_W      (WIND_W),
    .TEMP_W      (TEMP_W),
    .CAUTION_WIND(CAUTION_WIND),
    .HIGH_WIND   (HIGH_WIND),
    .EMERG_WIND  (EMERG_WIND),
    .HIGH_TEMP   (HIGH_TEMP),
    .EMERG_TEMP  (EMERG_TEMP)
  ) u_classify (
    .thunderstorm(thunderstorm),
    .wind        (wind),
    .visibility  (visibility),
    .temperature (temperature),
    .target      (target_p0)
  );

  ecsu_state_e      state_p1;
  logic [CNT_W-1:0] esc_cnt_p1;
  logic [CNT_W-1:0] clr_cnt_p1;

  ecsu_state_e      state_nx;
  logic [CNT_W-1:0] esc_nx;
  logic [CNT_W-1:0] clr_nx;
  logic [CNT_W-1:0] esc_inc;
  logic [CNT_W-1:0] clr_inc;

  always_comb begin
    state_nx = state_p1;
    esc_nx   = esc_cnt_p1;
    clr_nx   = clr_cnt_p1;
    esc_inc  = esc_cnt_p1 + CNT_W'(1);
    clr_inc  = clr_cnt_p1 + CNT_W'(1);

    if (sample_valid) begin
      if (target_p0 > state_p1) begin
        clr_nx = '0;
        if (esc_inc == ESC_LIM) begin
          // EMERGENCY is only entered from HIGH_ALERT; lower levels stop there.
          state_nx = (target_p0 == EMERGENCY && state_p1 != HIGH_ALERT) ?
                     HIGH_ALERT : target_p0;
          esc_nx   = '0;
        end else begin
          esc_nx = esc_inc;
        end
      end else if (target_p0 < state_p1) begin
        esc_nx = '0;
        if (state_p1 == EMERGENCY) begin
          // No dwell exit from EMERGENCY; the dwell count saturates short of
          // its limit so it cannot wrap while waiting for ack.
          if (ack) begin
            state_nx = HIGH_ALERT;
            clr_nx   = '0;
          end else if (clr_inc != CLR_LIM) begin
            clr_nx = clr_inc;
          end
        end else if (clr_inc == CLR_LIM) begin
          state_nx = ecsu_state_e'(state_p1 - 2'd1);
          clr_nx   = '0;
        end else begin
          clr_nx = clr_inc;
        end
      end else begin
        esc_nx = '0;
        clr_nx = '0;
      end
    end
  end

  // Stage p1: registered state, counters and outputs derived from next state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_p1                <= ALL_CLEAR;
      esc_cnt_p1              <= '0;
      clr_cnt_p1              <= '0;
      severe_weather          <= 1'b0;
      emergency_landing_alert <= 1'b0;
      state_changed           <= 1'b0;
    end else begin
      state_p1                <= state_nx;
      esc_cnt_p1              <= esc_nx;
      clr_cnt_p1              <= clr_nx;
      severe_weather          <= (state_nx == HIGH_ALERT) || (state_nx == EMERGENCY);
      emergency_landing_alert <= (state_nx == EMERGENCY);
      state_changed           <= (state_nx != state_p1);
    end
  end

  assign ECSU_state = state_p1;

endmodule

// File: tb/tb_ecsu_persist.sv
module tb_ecsu_persist;

  logic              CLK;
  logic              RST;
  logic              sample_valid;
  logic              thunderstorm;
  logic        [5:0] wind;
  logic        [1:0] visibility;
  logic signed [7:0] temperature;
  logic              ack;
  logic              severe_weather;
  logic              emergency_landing_alert;
  logic        [1:0] ECSU_state;
  logic              state_changed;

  int total = 0;
  int bad   = 0;

  ecsu_persist dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .sample_valid           (sample_valid),
    .thunderstorm           (thunderstorm),
    .wind                   (wind),
    .visibility             (visibility),
    .temperature            (temperature),
    .ack                    (ack),
    .severe_weather         (severe_weather),
    .emergency_landing_alert(emergency_landing_alert),
    .ECSU_state             (ECSU_state),
    .state_changed          (state_changed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog expired: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Apply one set of inputs, let one rising edge accept it, return 1 time
  // unit after that edge.
  task automatic drive(input logic v, input logic [5:0] w, input logic [1:0] vis,
                       input logic signed [7:0] t, input logic th, input logic a);
    sample_valid = v;
    wind         = w;
    visibility   = vis;
    temperature  = t;
    thunderstorm = th;
    ack          = a;
    @(posedge CLK);
    #1;
  endtask

  task automatic calm(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 6'd5, 2'b00, 8'sd20, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #2 RST = 1'b1;
    #2 RST = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d want=0", ECSU_state); end
    total++; if (severe_weather !== 1'b0) begin bad++; $display("FAIL reset_severe got=%b want=0", severe_weather); end
    total++; if (emergency_landing_alert !== 1'b0) begin bad++; $display("FAIL reset_alert got=%b want=0", emergency_landing_alert); end
    total++; if (state_changed !== 1'b0) begin bad++; $display("FAIL reset_changed got=%b want=0", state_changed); end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_persistence();
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL persist_one_sample got=%0d want=0", ECSU_state); end
    drive(1'b1, 6'd5, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL persist_then_calm got=%0d want=0", ECSU_state); end
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL persist_first got=%0d want=0", ECSU_state); end
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b01) begin bad++; $display("FAIL persist_second got=%0d want=1", ECSU_state); end
    total++; if (state_changed !== 1'b1) begin bad++; $display("FAIL persist_pulse got=%b want=1", state_changed); end
    total++; if (severe_weather !== 1'b0) begin bad++; $display("FAIL persist_severe got=%b want=0", severe_weather); end
    calm(1);
    total++; if (state_changed !== 1'b0) begin bad++; $display("FAIL persist_pulse_end got=%b want=0", state_changed); end
    calm(2);
    total++; if (ECSU_state !== 2'b01) begin bad++; $display("FAIL persist_dwell3 got=%0d want=1", ECSU_state); end
    calm(1);
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL persist_dwell4 got=%0d want=0", ECSU_state); end
    total++; if (state_changed !== 1'b1) begin bad++; $display("FAIL persist_down_pulse got=%b want=1", state_changed); end
  endtask

  task automatic test_gated_escalation();
    drive(1'b1, 6'd5, 2'b00, 8'sd45, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL gated_first got=%0d want=0", ECSU_state); end
    drive(1'b1, 6'd5, 2'b00, 8'sd45, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b10) begin bad++; $display("FAIL gated_to_high got=%0d want=2", ECSU_state); end
    total++; if (severe_weather !== 1'b1) begin bad++; $display("FAIL gated_severe got=%b want=1", severe_weather); end
    total++; if (emergency_landing_alert !== 1'b0) begin bad++; $display("FAIL gated_alert got=%b want=0", emergency_landing_alert); end
    drive(1'b1, 6'd5, 2'b00, 8'sd45, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b10) begin bad++; $display("FAIL gated_third got=%0d want=2", ECSU_state); end
    drive(1'b1, 6'd5, 2'b00, 8'sd45, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b11) begin bad++; $display("FAIL gated_to_emerg got=%0d want=3", ECSU_state); end
    total++; if (emergency_landing_alert !== 1'b1) begin bad++; $display("FAIL gated_emerg_alert got=%b want=1", emergency_landing_alert); end
  endtask

  task automatic test_emergency_latch();
    calm(10);
    total++; if (ECSU_state !== 2'b11) begin bad++; $display("FAIL latch_hold got=%0d want=3", ECSU_state); end
    total++; if (state_changed !== 1'b0) begin bad++; $display("FAIL latch_no_pulse got=%b want=0", state_changed); end
    drive(1'b1, 6'd5, 2'b00, 8'sd20, 1'b0, 1'b1);
    total++; if (ECSU_state !== 2'b10) begin bad++; $display("FAIL latch_ack got=%0d want=2", ECSU_state); end
    total++; if (state_changed !== 1'b1) begin bad++; $display("FAIL latch_ack_pulse got=%b want=1", state_changed); end
    total++; if (emergency_landing_alert !== 1'b0) begin bad++; $display("FAIL latch_ack_alert got=%b want=0", emergency_landing_alert); end
    calm(3);
    total++; if (ECSU_state !== 2'b10) begin bad++; $display("FAIL latch_dwell3 got=%0d want=2", ECSU_state); end
    calm(1);
    total++; if (ECSU_state !== 2'b01) begin bad++; $display("FAIL latch_to_caution got=%0d want=1", ECSU_state); end
    total++; if (severe_weather !== 1'b0) begin bad++; $display("FAIL latch_caution_severe got=%b want=0", severe_weather); end
    calm(4);
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL latch_to_clear got=%0d want=0", ECSU_state); end
  endtask

  task automatic test_valid_gaps();
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 6'd30, 2'b11, 8'sd100, 1'b1, 1'b0);
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL gap_invalid_ignored got=%0d want=0", ECSU_state); end
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b01) begin bad++; $display("FAIL gap_second_valid got=%0d want=1", ECSU_state); end
    calm(4);
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL gap_back_clear got=%0d want=0", ECSU_state); end
  endtask

  task automatic test_flip();
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b01) begin bad++; $display("FAIL flip_setup got=%0d want=1", ECSU_state); end
    drive(1'b1, 6'd16, 2'b00, 8'sd20, 1'b0, 1'b0);
    calm(1);
    drive(1'b1, 6'd16, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b01) begin bad++; $display("FAIL flip_restart got=%0d want=1", ECSU_state); end
    drive(1'b1, 6'd16, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b10) begin bad++; $display("FAIL flip_fresh_two got=%0d want=2", ECSU_state); end
    do_reset();
  endtask

  task automatic test_magnitude();
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    drive(1'b1, 6'd16, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b10) begin bad++; $display("FAIL magnitude_final got=%0d want=2", ECSU_state); end
    do_reset();
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    drive(1'b1, 6'd21, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b10) begin bad++; $display("FAIL magnitude_gated got=%0d want=2", ECSU_state); end
    do_reset();
  endtask

  typedef struct {
    logic              pre_high;
    logic        [5:0] w;
    logic        [1:0] vis;
    logic signed [7:0] t;
    logic              th;
    logic        [1:0] exp_state;
  } bvec_t;

  bvec_t bv [14] = '{
    '{1'b0, 6'd5,  2'b00, -8'sd35, 1'b0, 2'b00},
    '{1'b0, 6'd5,  2'b00, -8'sd36, 1'b0, 2'b10},
    '{1'b0, 6'd10, 2'b00,  8'sd20, 1'b0, 2'b00},
    '{1'b0, 6'd15, 2'b00,  8'sd20, 1'b0, 2'b01},
    '{1'b0, 6'd16, 2'b00,  8'sd20, 1'b0, 2'b10},
    '{1'b1, 6'd20, 2'b00,  8'sd20, 1'b0, 2'b10},
    '{1'b1, 6'd21, 2'b00,  8'sd20, 1'b0, 2'b11},
    '{1'b0, 6'd5,  2'b10,  8'sd20, 1'b0, 2'b01},
    '{1'b0, 6'd5,  2'b11,  8'sd20, 1'b0, 2'b10},
    '{1'b0, 6'd5,  2'b00,  8'sd20, 1'b1, 2'b10},
    '{1'b1, 6'd5,  2'b00,  8'sd40, 1'b0, 2'b10},
    '{1'b1, 6'd5,  2'b00,  8'sd41, 1'b0, 2'b11},
    '{1'b1, 6'd5,  2'b00, -8'sd41, 1'b0, 2'b11},
    '{1'b0, 6'd5,  2'b01,  8'sd35, 1'b0, 2'b01}
  };

  task automatic test_boundaries();
    for (int i = 0; i < 14; i++) begin
      do_reset();
      if (bv[i].pre_high) begin
        drive(1'b1, 6'd16, 2'b00, 8'sd20, 1'b0, 1'b0);
        drive(1'b1, 6'd16, 2'b00, 8'sd20, 1'b0, 1'b0);
      end
      drive(1'b1, bv[i].w, bv[i].vis, bv[i].t, bv[i].th, 1'b0);
      drive(1'b1, bv[i].w, bv[i].vis, bv[i].t, bv[i].th, 1'b0);
      total++;
      if (ECSU_state !== bv[i].exp_state) begin
        bad++;
        $display("FAIL boundary_%0d wind=%0d vis=%0d temp=%0d th=%b got=%0d want=%0d",
                 i, bv[i].w, bv[i].vis, bv[i].t, bv[i].th, ECSU_state, bv[i].exp_state);
      end
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 6'd5, 2'b00, 8'sd45, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b11) begin bad++; $display("FAIL areset_setup got=%0d want=3", ECSU_state); end
    #2 RST = 1'b1;
    #1;
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL areset_state got=%0d want=0", ECSU_state); end
    total++; if (severe_weather !== 1'b0) begin bad++; $display("FAIL areset_severe got=%b want=0", severe_weather); end
    total++; if (emergency_landing_alert !== 1'b0) begin bad++; $display("FAIL areset_alert got=%b want=0", emergency_landing_alert); end
    total++; if (state_changed !== 1'b0) begin bad++; $display("FAIL areset_changed got=%b want=0", state_changed); end
    sample_valid = 1'b1;
    wind         = 6'd30;
    ack          = 1'b1;
    @(posedge CLK);
    #1;
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL areset_override got=%0d want=0", ECSU_state); end
    RST = 1'b0;
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    do_reset();
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b00) begin bad++; $display("FAIL areset_count_cleared got=%0d want=0", ECSU_state); end
    drive(1'b1, 6'd12, 2'b00, 8'sd20, 1'b0, 1'b0);
    total++; if (ECSU_state !== 2'b01) begin bad++; $display("FAIL areset_after_count got=%0d want=1", ECSU_state); end
  endtask

  initial begin
    RST          = 1'b1;
    sample_valid = 1'b0;
    thunderstorm = 1'b0;
    wind         = 6'd5;
    visibility   = 2'b00;
    temperature  = 8'sd20;
    ack          = 1'b0;

    test_reset();
    test_persistence();
    test_gated_escalation();
    test_emergency_latch();
    test_valid_gaps();
    test_flip();
    test_magnitude();
    test_boundaries();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
